// File: rtl/bcd_updown_counter.sv
// Cascaded modulo-N up/down counter with synchronous clear and parallel load,
// a combinational terminal count, a registered wrap pulse and a sticky flag
// for loads that carry out-of-range digits.
module bcd_updown_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  localparam int DW     = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 en,
  input  logic                 up,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  localparam logic [DW-1:0] DMAX = DW'(MODULUS - 1);
  localparam logic [DW:0]   MODW = (DW + 1)'(MODULUS);

  logic [DIGITS*DW-1:0] q_r;
  logic [DIGITS*DW-1:0] q_nxt;
  logic                 all_max;
  logic                 all_zero;
  logic                 load_bad;
  logic                 wrap_r;
  logic                 err_r;

  // Whole-counter extremes, used for terminal count.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (q_r[k*DW +: DW] != DMAX) all_max  = 1'b0;
      if (q_r[k*DW +: DW] != '0)   all_zero = 1'b0;
    end
  end

  assign tc = en & ((up & all_max) | (~up & all_zero));

  // Next count: clear beats load beats count; the carry/borrow ripples
  // upward only while every lower digit sits at its wrap value.
  always_comb begin
    logic [DW-1:0] d;
    logic          ripple;
    q_nxt    = q_r;
    load_bad = 1'b0;
    ripple   = 1'b1;
    d        = '0;
    if (clear) begin
      q_nxt = '0;
    end else if (load) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        d = load_val[k*DW +: DW];
        if ({1'b0, d} >= MODW) begin
          q_nxt[k*DW +: DW] = '0;
          load_bad          = 1'b1;
        end else begin
          q_nxt[k*DW +: DW] = d;
        end
      end
    end else if (en) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        d = q_r[k*DW +: DW];
        if (ripple) begin
          if (up) q_nxt[k*DW +: DW] = (d == DMAX) ? '0 : d + DW'(1);
          else    q_nxt[k*DW +: DW] = (d == '0) ? DMAX : d - DW'(1);
        end
        ripple = ripple & (up ? (d == DMAX) : (d == '0));
      end
    end
  end

  // State registers; wrap is the terminal count suppressed by clear/load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= tc & ~clear & ~load;
      if (clear)                err_r <= 1'b0;
      else if (load && load_bad) err_r <= 1'b1;
    end
  end

  assign q        = q_r;
  assign wrap     = wrap_r;
  assign load_err = err_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=2, MODULUS=10): the driver
// pushes expected post-edge outputs, the monitor pops and compares after
// every rising edge.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n, clear, load, en, up;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       tc, wrap, load_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
    logic       err;
    logic       tc;
  } exp_t;

  exp_t sb[$];

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must look like just after the following rising edge.
  task automatic step(input logic rn, input logic c, input logic l,
                      input logic [7:0] lv, input logic e, input logic u,
                      input logic [7:0] eq, input logic ew, input logic eerr,
                      input logic etc);
    exp_t x;
    @(negedge clk);
    reset_n = rn; clear = c; load = l; load_val = lv; en = e; up = u;
    x.q = eq; x.wrap = ew; x.err = eerr; x.tc = etc;
    sb.push_back(x);
  endtask

  // Monitor: every rising edge presents a new output set.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("q",        q,               x.q);
      chk("wrap",     {7'd0, wrap},    {7'd0, x.wrap});
      chk("load_err", {7'd0, load_err}, {7'd0, x.err});
      chk("tc",       {7'd0, tc},      {7'd0, x.tc});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int mv, h, o;
    logic merr, ew, tcp, bad, rn, c, l, e, u;
    logic [7:0] lv;
    exp_t x;

    reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0;
    #3;
    chk("reset_q",    q,                8'h00);
    chk("reset_wrap", {7'd0, wrap},     8'h00);
    chk("reset_err",  {7'd0, load_err}, 8'h00);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    // Full up-count 00..99 -> 00
    for (int i = 0; i < 100; i++)
      step(1, 0, 0, 8'h00, 1, 1, bcd((i + 1) % 100), (i == 99), 0, (i == 98));

    // Down from 00 wraps to 99, then ten more steps to 89
    step(1, 0, 0, 8'h00, 1, 0, 8'h99, 1, 0, 0);
    for (int j = 1; j <= 10; j++)
      step(1, 0, 0, 8'h00, 1, 0, bcd(99 - j), 0, 0, 0);

    // Legal load, illegal load (sticky flag through counting), clear
    step(1, 0, 1, 8'h47, 0, 0, 8'h47, 0, 0, 0);
    step(1, 0, 1, 8'hC3, 0, 0, 8'h03, 0, 1, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h04, 0, 1, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h05, 0, 1, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h06, 0, 1, 0);
    step(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    // Priority at 99: clear over load over count, no wrap
    step(1, 0, 1, 8'h99, 1, 1, 8'h99, 0, 0, 1);
    step(1, 1, 1, 8'h05, 1, 1, 8'h00, 0, 0, 0);
    step(1, 0, 1, 8'h99, 0, 0, 8'h99, 0, 0, 0);
    step(1, 0, 1, 8'h05, 1, 1, 8'h05, 0, 0, 0);
    // Direction change takes effect on the same edge
    step(1, 0, 0, 8'h00, 1, 1, 8'h06, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 8'h05, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h06, 0, 0, 0);
    // Down terminal count at 00; clear beats a simultaneous illegal load
    step(1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 1, 8'hC3, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 1, 8'h3A, 0, 0, 8'h30, 0, 1, 0);

    // Asynchronous reset between edges at q=37
    step(1, 0, 1, 8'h36, 0, 0, 8'h36, 0, 1, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h37, 0, 1, 0);
    @(negedge clk);
    clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_q",   q,                8'h00);
    chk("async_err", {7'd0, load_err}, 8'h00);
    x.q = 8'h00; x.wrap = 0; x.err = 0; x.tc = 0;
    sb.push_back(x);
    step(0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h01, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h02, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 1, 8'h03, 0, 0, 0);

    // Random run against a decimal-integer model
    mv = 3; merr = 0;
    for (int n = 0; n < 2000; n++) begin
      rn = ($urandom_range(31) != 0);
      c  = ($urandom_range(15) == 0);
      l  = ($urandom_range(7) == 0);
      lv = {4'($urandom_range(11)), 4'($urandom_range(11))};
      e  = ($urandom_range(3) != 0);
      u  = 1'($urandom_range(1));
      if (!rn) begin
        mv = 0; merr = 0; ew = 0;
      end else begin
        tcp = e && ((u && mv == 99) || (!u && mv == 0));
        ew  = tcp && !c && !l;
        if (c) begin
          mv = 0; merr = 0;
        end else if (l) begin
          h = int'(lv[7:4]); o = int'(lv[3:0]);
          bad = (h > 9) || (o > 9);
          if (h > 9) h = 0;
          if (o > 9) o = 0;
          mv = h * 10 + o;
          if (bad) merr = 1;
        end else if (e) begin
          mv = u ? (mv + 1) % 100 : (mv + 99) % 100;
        end
      end
      step(rn, c, l, lv, e, u, bcd(mv), ew, merr,
           e && ((u && mv == 99) || (!u && mv == 0)));
    end

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
